// File: rtl/wbs_pkg.sv
// wbs_pkg
// Shared definitions for the word-to-byte sequencer: datapath widths, the
// FSM state type, the lane-index type and small lane-mask helpers.
// No ports (package).
package wbs_pkg;

  localparam int WBS_WORD_W = 32;
  localparam int WBS_BYTE_W = 8;
  localparam int WBS_LANES  = 4;

  // IDLE holds nothing; SEND holds a word with at least one lane left to emit.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } wbs_state_t;

  typedef logic [1:0] wbs_idx_t;

  // Widens a 4-bit lane enable into a 32-bit mask, one byte of ones per
  // enabled lane, so a word can be ANDed down to its enabled bytes.
  function automatic logic [WBS_WORD_W-1:0] wbs_expand_be(input logic [WBS_LANES-1:0] be);
    logic [WBS_WORD_W-1:0] mask;
    mask = '0;
    for (int k = 0; k < WBS_LANES; k++) begin
      mask[WBS_BYTE_W*k +: WBS_BYTE_W] = {WBS_BYTE_W{be[k]}};
    end
    return mask;
  endfunction

  // True when exactly one lane bit is set, i.e. the current byte is the
  // final one of the word.
  function automatic logic wbs_onehot(input logic [WBS_LANES-1:0] m);
    return (m != '0) && ((m & (m - 4'd1)) == '0);
  endfunction

endpackage

// File: rtl/wbs_next_lane.sv
// wbs_next_lane
// Combinational priority picker that returns the first set lane of a mask
// in the configured lane order. Serves both for the first lane of a newly
// loaded word and for the next lane after each byte leaves.
// Parameters:
//   LSB_FIRST : 1 picks the lowest set bit, 0 picks the highest.
// Ports:
//   i_mask  [3:0] : candidate lanes
//   o_found       : at least one lane is set
//   o_idx   [1:0] : chosen lane (0 when nothing is set)
module wbs_next_lane
  import wbs_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [WBS_LANES-1:0] i_mask,
  output logic                 o_found,
  output wbs_idx_t             o_idx
);

  // Later loop iterations overwrite earlier ones, so the scan direction is
  // chosen such that the winning lane is visited last.
  always_comb begin
    o_found = |i_mask;
    o_idx   = '0;
    if (LSB_FIRST) begin
      for (int k = WBS_LANES - 1; k >= 0; k--) begin
        if (i_mask[k]) o_idx = wbs_idx_t'(k);
      end
    end else begin
      for (int k = 0; k < WBS_LANES; k++) begin
        if (i_mask[k]) o_idx = wbs_idx_t'(k);
      end
    end
  end

endmodule

// File: rtl/word_byte_sequencer.sv
// word_byte_sequencer
// Serializes 32-bit words into a byte stream, stepping across the enabled
// byte lanes in a build-time lane order. Valid/ready on both sides; a new
// word loads on the same edge that the previous word's last byte leaves.
// Build option:
//   WBS_PARITY_EN : when defined, out_parity carries the even parity of the
//                   word's enabled bytes alongside its last byte; otherwise
//                   out_parity is tied to 0.
// Parameters:
//   LSB_FIRST : 1 emits lane 0 first, 0 emits lane 3 first.
// Ports:
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   in_valid/ready  : word handshake
//   in_data  [31:0] : word to serialize
//   in_be    [3:0]  : lane enables (bit k enables in_data[8k +: 8])
//   out_valid/ready : byte handshake
//   out_byte [7:0]  : current lane byte
//   out_last        : final enabled byte of the word
//   out_parity      : XOR of all enabled bytes, qualified by out_last
module word_byte_sequencer
  import wbs_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WBS_WORD_W-1:0] in_data,
  input  logic [WBS_LANES-1:0]  in_be,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WBS_BYTE_W-1:0] out_byte,
  output logic                  out_last,
  output logic                  out_parity
);

  wbs_state_t            r_state;
  logic [WBS_WORD_W-1:0] r_word;
  logic [WBS_LANES-1:0]  r_rem;
  wbs_idx_t              r_idx;

  wbs_state_t            w_stateNext;
  logic [WBS_WORD_W-1:0] w_wordNext;
  logic [WBS_LANES-1:0]  w_remNext;
  wbs_idx_t              w_idxNext;

  logic                  w_xfer;
  logic                  w_accept;
  logic                  w_loadFound;
  wbs_idx_t              w_loadIdx;
  logic [WBS_LANES-1:0]  w_remCleared;
  logic                  w_nextFound;
  wbs_idx_t              w_nextIdx;

  // First lane of the incoming word.
  wbs_next_lane #(.LSB_FIRST(LSB_FIRST)) u_loadPick (
    .i_mask  (in_be),
    .o_found (w_loadFound),
    .o_idx   (w_loadIdx)
  );

  // Next lane once the current one has been handed over; no lane found
  // means the word is finished.
  assign w_remCleared = r_rem & ~(4'b0001 << r_idx);

  wbs_next_lane #(.LSB_FIRST(LSB_FIRST)) u_nextPick (
    .i_mask  (w_remCleared),
    .o_found (w_nextFound),
    .o_idx   (w_nextIdx)
  );

  assign out_valid = (r_state == SEND);
  assign out_byte  = out_valid ? r_word[{r_idx, 3'b000} +: WBS_BYTE_W] : '0;
  assign out_last  = out_valid && wbs_onehot(r_rem);
  assign w_xfer    = out_valid && out_ready;

  // Ready while empty, or while the last byte is leaving so the next word
  // slots in without a bubble. Held low during reset so no word is taken.
  assign in_ready  = !rst && ((r_state == IDLE) || (w_xfer && out_last));
  assign w_accept  = in_valid && in_ready;

  // Next-state logic: a byte transfer advances the lane cursor; an accepted
  // word with any enabled lane overrides that and loads fresh. A word with
  // no enabled lanes is swallowed and leaves the state as the transfer set it.
  always_comb begin
    w_stateNext = r_state;
    w_wordNext  = r_word;
    w_remNext   = r_rem;
    w_idxNext   = r_idx;
    if (w_xfer) begin
      w_remNext = w_remCleared;
      w_idxNext = w_nextIdx;
      if (!w_nextFound) w_stateNext = IDLE;
    end
    if (w_accept && w_loadFound) begin
      w_stateNext = SEND;
      w_wordNext  = in_data;
      w_remNext   = in_be;
      w_idxNext   = w_loadIdx;
    end
  end

  // State register with synchronous reset; reset drops any held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_rem   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_word  <= w_wordNext;
      r_rem   <= w_remNext;
      r_idx   <= w_idxNext;
    end
  end

`ifdef WBS_PARITY_EN
  logic r_par;

  // Parity is captured once at load from the enabled bytes only, so it is
  // ready by the time the last byte appears.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (w_accept && w_loadFound) begin
      r_par <= ^(in_data & wbs_expand_be(in_be));
    end
  end

  assign out_parity = out_last ? r_par : 1'b0;
`else
  assign out_parity = 1'b0;
`endif

endmodule

// File: doc/word_byte_sequencer.md
# word_byte_sequencer

Serializes 32-bit words into a byte stream by stepping an indexed part-select (`data[8*i +: 8]`) across the four byte lanes. The lane order is fixed at build time. A per-word byte-enable mask lets it skip unused lanes. It sits between a word-wide producer, such as a register or address-word source, and a byte-wide consumer, such as a UART or SPI TX byte port. Both sides use a valid/ready handshake. As an option, it reports the even parity of each word's transmitted bytes alongside the final byte.

## Interface
- `LSB_FIRST`, default 1: 1 emits lane 0 (bits 7:0) first; 0 emits lane 3 (bits 31:24) first.
- `clk` input 1: single clock; everything is rising-edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: the producer has a word.
- `in_ready` output 1: the block accepts a word this cycle.
- `in_data` input 32: word to serialize.
- `in_be` input 4: lane enables; bit k enables `in_data[8*k +: 8]`.
- `out_valid` output 1: `out_byte` is valid.
- `out_ready` input 1: the consumer takes the byte.
- `out_byte` output 8: current lane byte.
- `out_last` output 1: this is the final enabled byte of the word.
- `out_parity` output 1: XOR-reduce of all enabled bytes of the word; meaningful only when `out_last`=1.

## Operation
- States:
  - IDLE: no word held.
  - SEND: a word is held, with a 4-bit remaining-lane mask `rem` and a 2-bit current index `idx`.
- Registers: `word_q[31:0]`, `rem[3:0]`, `idx[1:0]`, `par_q`.
- IDLE to SEND: on `in_valid && in_ready` with `in_be` != 0.
  - Latch `in_data`.
  - Set `rem` to `in_be`.
  - Set `idx` to the first set bit of `in_be` in lane order: lowest bit if `LSB_FIRST`, highest bit otherwise.
- All-zero word: a word with `in_be`=0 is accepted and discarded. No output is produced and the state stays IDLE.
- Output in SEND:
  - `out_byte` = `word_q[8*idx +: 8]`.
  - `out_last` = (`rem` has exactly one bit set).
- On each byte transfer (`out_valid && out_ready`):
  - Clear `rem[idx]`.
  - Advance `idx` to the next set bit of `rem` in lane order.
- SEND to IDLE: when the last byte transfers, unless a new word is accepted in the same cycle (see below).
- `in_ready` = IDLE || (`out_valid && out_ready && out_last`). This gives back-to-back words with no bubble: the new word loads on the same edge as the last-byte transfer.
- Both signals are stable under backpressure:
  - `out_byte`/`out_last` hold while `out_valid && !out_ready`.
  - The producer must hold `in_data`/`in_be` while `in_valid && !in_ready`.
- Width rule: `idx` is always in 0..3, so no part-select out of range is possible. `rem` only loses bits, never gains them, until the next load.

## Timing
- Reset values: `in_ready`=0 during the reset cycle, then 1 (IDLE). `out_valid`=0, `out_byte`=8'h00, `out_last`=0, `out_parity`=0, `rem`=0, `idx`=0.
- Latency: word accepted at edge N gives its first byte valid from N+1.
- Throughput: 1 byte/cycle when `out_ready`=1. A full word takes 4 cycles; a word with k enabled lanes takes k cycles.
- Reset mid-word: `rst`=1 at any edge discards the held word and any remaining bytes; no `out_last` is emitted.
- Reset during a handshake: `rst` has priority over a simultaneous input handshake, and the word is not accepted.

## Configuration
- `WBS_PARITY_EN` defined:
  - `par_q` = ^(`in_data` & lane-expanded `in_be`), computed at load.
  - `out_parity` = `par_q` when SEND && `out_last`, else 0.
- `WBS_PARITY_EN` undefined: the `par_q` logic is removed and the `out_parity` port remains, tied to 0.

## Structure
- Package `wbs_pkg`:
  - `WBS_WORD_W`=32, `WBS_BYTE_W`=8, `WBS_LANES`=4.
  - `wbs_state_t` enum {IDLE, SEND}.
  - Lane-index typedef `wbs_idx_t` (2 bits).
- Sub-module `wbs_next_lane`: combinational priority picker. It takes a 4-bit mask and the `LSB_FIRST` setting and returns `{found, idx}`. It is used both for the first lane at load and for the next lane on each transfer.

## Test plan
- `LSB_FIRST`=1, `in_data`=32'hFACE_CAFE, `in_be`=4'hF, `out_ready`=1 → bytes FE, CA, CE, FA on 4 consecutive cycles; `out_last` only on FA; `out_parity`=0.
- `LSB_FIRST`=0, same word → FA, CE, CA, FE; `out_last` on FE.
- `in_data`=32'h1122_3344, `in_be`=4'b0101 → 44 then 22 (`out_last`); parity 0. Next `in_data`=32'h0000_0001, `in_be`=4'h1 → 01 with `out_last`=1, `out_parity`=1 (when `WBS_PARITY_EN` is defined).
- Back-to-back: two full words offered continuously with `out_ready`=1 → 8 bytes in 8 consecutive cycles, no gap; `in_ready` pulses on the last-byte cycle.
- Backpressure: `out_ready` toggles 1,0,0,1,... → `out_byte` holds during stalls; no byte is lost or duplicated; `in_be`=0 word → accepted, zero output bytes.
- `rst` asserted after the 2nd byte of 32'hFACE_CAFE → next cycle `out_valid`=0, `in_ready`=1 after reset deasserts; a new word starts cleanly from its first lane.
